// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - 8N1 UART receiver with majority vote, one-entry holding register and RTS.
module uart_rx_frame #(
    parameter int CLK_FREQ_HZ = 125_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_reset_request,
    input  logic        uart_rx,
    input  logic [15:0] baud_divisor,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_busy,
    output logic        frame_error,
    output logic        overrun,
    output logic        uart_rts_n
);

    localparam int SC_W        = $clog2(OVERSAMPLE);
    localparam int MID         = OVERSAMPLE / 2;
    localparam int DIV_RAW     = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DEFAULT_DIV = (DIV_RAW < 1) ? 1 : ((DIV_RAW > 65535) ? 65535 : DIV_RAW);

    localparam logic [15:0]     DEF_DIV16 = 16'(DEFAULT_DIV);
    localparam logic [SC_W-1:0] SC_LAST   = SC_W'(OVERSAMPLE - 1);
    localparam logic [SC_W-1:0] SC_VA     = SC_W'(MID - 1);
    localparam logic [SC_W-1:0] SC_VB     = SC_W'(MID);
    localparam logic [SC_W-1:0] SC_VC     = SC_W'(MID + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_m;
    logic            rx_s;
    logic [15:0]     div_lat;
    logic [15:0]     eff_div;
    logic [15:0]     tcnt;
    logic [SC_W-1:0] sc;
    logic            v0;
    logic            v1;
    logic [7:0]      shreg;
    logic [2:0]      bit_idx;

    logic tick;
    logic vote;
    logic vote_pt;
    logic bit_end;
    logic run;
    logic start_entry;
    logic shift_en;
    logic bit_adv;
    logic bit_clr;
    logic commit;
    logic ferr;

    // Synchroniser resets high so the line reads idle straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    assign eff_div = (baud_divisor == 16'd0) ? DEF_DIV16 : baud_divisor;
    assign tick    = (tcnt == div_lat - 16'd1);
    assign vote_pt = tick && (sc == SC_VC);
    assign bit_end = tick && (sc == SC_LAST);
    assign vote    = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
    assign run     = (state == S_START) || (state == S_DATA) || (state == S_STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_entry = 1'b0;
        shift_en    = 1'b0;
        bit_adv     = 1'b0;
        bit_clr     = 1'b0;
        commit      = 1'b0;
        ferr        = 1'b0;
        if (soft_reset_request) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_nxt   = S_START;
                        start_entry = 1'b1;
                    end
                end
                S_START: begin
                    if (vote_pt && vote) begin
                        state_nxt = S_IDLE;
                    end else if (bit_end) begin
                        state_nxt = S_DATA;
                        bit_clr   = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_en = vote_pt;
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state_nxt = S_STOP;
                        end else begin
                            bit_adv = 1'b1;
                        end
                    end
                end
                // Decided at mid stop bit so a start bit right after one stop bit is not missed.
                S_STOP: begin
                    if (vote_pt) begin
                        if (vote) begin
                            commit    = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            ferr      = 1'b1;
                            state_nxt = S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_lat     <= DEF_DIV16;
            tcnt        <= 16'd0;
            sc          <= '0;
            v0          <= 1'b0;
            v1          <= 1'b0;
            shreg       <= 8'd0;
            bit_idx     <= 3'd0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else if (soft_reset_request) begin
            tcnt        <= 16'd0;
            sc          <= '0;
            v0          <= 1'b0;
            v1          <= 1'b0;
            shreg       <= 8'd0;
            bit_idx     <= 3'd0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= ferr;
            overrun     <= 1'b0;

            // Divisor only follows the input between frames.
            if (state == S_IDLE) begin
                div_lat <= eff_div;
            end

            if (start_entry) begin
                tcnt <= 16'd0;
                sc   <= '0;
            end else if (run) begin
                if (tick) begin
                    tcnt <= 16'd0;
                    sc   <= (sc == SC_LAST) ? '0 : sc + SC_W'(1);
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
            end

            if (run && tick && (sc == SC_VA)) begin
                v0 <= rx_s;
            end
            if (run && tick && (sc == SC_VB)) begin
                v1 <= rx_s;
            end

            if (shift_en) begin
                shreg <= {vote, shreg[7:1]};
            end

            if (bit_clr) begin
                bit_idx <= 3'd0;
            end else if (bit_adv) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (commit) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy    = (state != S_IDLE);
    assign uart_rts_n = rx_valid;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame with randomized frames.
module tb_uart_rx_frame;

    localparam int OS      = 16;
    localparam int DEF_DIV = 7;
    localparam int CLKF    = 9600 * OS * DEF_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        soft_reset_request;
    logic        uart_rx;
    logic [15:0] baud_divisor;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        frame_error;
    logic        overrun;
    logic        uart_rts_n;

    uart_rx_frame #(
        .CLK_FREQ_HZ(CLKF),
        .BAUD_RATE  (9600),
        .OVERSAMPLE (OS)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .soft_reset_request(soft_reset_request),
        .uart_rx           (uart_rx),
        .baud_divisor      (baud_divisor),
        .rx_ready          (rx_ready),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_busy           (rx_busy),
        .frame_error       (frame_error),
        .overrun           (overrun),
        .uart_rts_n        (uart_rts_n)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         exp_fe = 0;
    int         exp_ov = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         both_cnt = 0;
    int         stab_viol = 0;
    int         rise_cnt = 0;
    bit         model_full = 1'b0;
    bit         busy_seen = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every newly presented byte is popped from the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && !prev_valid) begin
                rise_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (prev_valid && rx_valid && (rx_data !== prev_data)) stab_viol++;
            if (frame_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_error && overrun) both_cnt++;
            if (rx_busy) busy_seen = 1'b1;
        end
        prev_valid = rx_valid;
        prev_data  = rx_data;
    end

    // Reference model: what a whole frame should produce given the consumer's readiness.
    task automatic model_frame(input logic [7:0] d, input bit stop);
        if (!stop) begin
            exp_fe++;
        end else if (model_full && !rx_ready) begin
            exp_ov++;
        end else begin
            exp_q.push_back(d);
            model_full = !rx_ready;
        end
    endtask

    task automatic drive_bits(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int div);
        int bp;
        bp = div * OS;
        drive_bits(1'b0, bp);
        for (int i = 0; i < 8; i++) drive_bits(d[i], bp);
        drive_bits(stop, bp);
    endtask

    task automatic rx_frame(input logic [7:0] d, input bit stop, input int div);
        model_frame(d, stop);
        send_frame(d, stop, div);
    endtask

    task automatic idle(input int n);
        drive_bits(1'b1, n);
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready   = 1'b0;
        model_full = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int sv;
        int div;
        int gap;
        bit stop;
        bit last_stop;
        logic [7:0] d;

        rst_n              = 1'b0;
        soft_reset_request = 1'b0;
        uart_rx            = 1'b1;
        rx_ready           = 1'b0;
        baud_divisor       = 16'd4;
        repeat (3) @(negedge clk);
        check("reset_outputs", {19'd0, rx_data, rx_valid, rx_busy, frame_error, overrun, uart_rts_n}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);

        // Basic receive, consumer not ready
        rx_frame(8'hA5, 1'b1, 4);
        idle(5);
        @(negedge clk);
        check("basic_valid", {31'd0, rx_valid}, 32'd1);
        check("basic_data", {24'd0, rx_data}, 32'hA5);
        check("basic_rts", {31'd0, uart_rts_n}, 32'd1);
        check("basic_no_fe", fe_cnt, exp_fe);
        @(posedge clk);
        #1;
        pulse_ready();
        @(negedge clk);
        check("basic_consumed", {31'd0, rx_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back, ready tied high
        rx_ready = 1'b1;
        rx_frame(8'h3C, 1'b1, 4);
        rx_frame(8'hC3, 1'b1, 4);
        idle(20);
        check("b2b_drained", exp_q.size(), 0);

        // Back-to-back, ready low: second byte overruns
        rx_ready = 1'b0;
        rx_frame(8'h3C, 1'b1, 4);
        rx_frame(8'hC3, 1'b1, 4);
        idle(20);
        @(negedge clk);
        check("overrun_count", ov_cnt, exp_ov);
        check("overrun_keeps_data", {24'd0, rx_data}, 32'h3C);
        check("overrun_valid", {31'd0, rx_valid}, 32'd1);
        @(posedge clk);
        #1;
        pulse_ready();

        // False start glitch
        rx_ready  = 1'b1;
        busy_seen = 1'b0;
        rc        = rise_cnt;
        drive_bits(1'b0, 20);
        idle(100);
        @(negedge clk);
        check("false_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("false_busy_low", {31'd0, rx_busy}, 32'd0);
        check("false_no_byte", rise_cnt, rc);
        check("false_no_fe", fe_cnt, exp_fe);
        @(posedge clk);
        #1;
        rx_frame(8'h55, 1'b1, 4);
        idle(10);

        // Framing error followed by a break
        rc = rise_cnt;
        rx_frame(8'h81, 1'b0, 4);
        drive_bits(1'b0, 1000);
        @(negedge clk);
        check("break_busy", {31'd0, rx_busy}, 32'd1);
        check("break_fe_once", fe_cnt, exp_fe);
        check("break_no_byte", rise_cnt, rc);
        @(posedge clk);
        #1;
        idle(50);
        rx_frame(8'h7E, 1'b1, 4);
        idle(10);

        // Default divisor, changed mid-frame
        baud_divisor = 16'd0;
        idle(5);
        fork
            rx_frame(8'h0F, 1'b1, DEF_DIV);
            begin
                repeat (DEF_DIV * OS * 4 + DEF_DIV * OS / 2) @(posedge clk);
                #1;
                baud_divisor = 16'd4;
            end
        join
        idle(20);
        rx_frame(8'($urandom), 1'b1, 4);
        idle(20);

        // Soft reset during bit 5 of 0xFF
        rx_ready = 1'b0;
        rx_frame(8'h5A, 1'b1, 4);
        idle(10);
        @(negedge clk);
        check("pre_soft_valid", {31'd0, rx_valid}, 32'd1);
        @(posedge clk);
        #1;
        fork
            send_frame(8'hFF, 1'b1, 4);
            begin
                repeat (4 * OS * 6 + 4 * OS / 2) @(posedge clk);
                #1;
                soft_reset_request = 1'b1;
                @(posedge clk);
                #1;
                soft_reset_request = 1'b0;
                model_full         = 1'b0;
                @(negedge clk);
                check("soft_valid_clear", {31'd0, rx_valid}, 32'd0);
                check("soft_idle", {31'd0, rx_busy}, 32'd0);
            end
        join
        idle(10);
        rx_ready = 1'b1;
        rx_frame(8'h12, 1'b1, 4);
        idle(10);

        // Randomized frames, random divisors, gaps and occasional bad stop bits
        last_stop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            div          = $urandom_range(6, 2);
            d            = 8'($urandom);
            stop         = ($urandom_range(4, 0) != 0);
            gap          = last_stop ? $urandom_range(30, 0) : $urandom_range(30, 4);
            baud_divisor = 16'(div);
            idle(gap + 1);
            rx_frame(d, stop, div);
            last_stop = stop;
        end
        idle(40);
        check("rand_drained", exp_q.size(), 0);
        check("rand_fe", fe_cnt, exp_fe);

        // Asynchronous reset mid-frame
        baud_divisor = 16'd4;
        rx_ready     = 1'b0;
        rx_frame(8'h96, 1'b1, 4);
        idle(10);
        fork
            send_frame(8'h00, 1'b1, 4);
            begin
                repeat (300) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                check("async_reset_outputs",
                      {19'd0, rx_data, rx_valid, rx_busy, frame_error, overrun, uart_rts_n}, 32'd0);
                model_full = 1'b0;
            end
        join
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        sv = exp_q.size();

        check("final_queue_empty", sv, 0);
        check("final_fe", fe_cnt, exp_fe);
        check("final_ov", ov_cnt, exp_ov);
        check("fe_ov_exclusive", both_cnt, 0);
        check("data_stable", stab_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
